boot_mode_seq: RTL and testbench
================================

Name: boot_mode_seq

Overview:
- Central sequencer for the board's two operating modes: UART program load and WORK (CPU run).
- Debounces and synchronises the UART/WORK trigger buttons and tracks the UART loader's done flag.
- Drives the registered control signals consumed by the top level: mode select (memory clock/address muxes), UART loader reset, CPU reset and delayed CPU enable.
- Sits between the button pins and the UART loader, CPU and instruction/data memory muxes.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable-high samples before a button press is accepted.
- WARMUP_CYCLES, 255: cycles spent in WARMUP, with CPU reset released and enable low, before RUN.
- CNT_W, 20: width of the shared debounce/warm-up counters; must hold max(DEBOUNCE_CYCLES, WARMUP_CYCLES).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- uart_btn_i  in  1  raw UART-mode button, asynchronous.
- work_btn_i  in  1  raw WORK-mode button, asynchronous.
- uart_done_i  in  1  UART loader done flag, from the loader clock domain.
- mode_o  out  1  1 = WORK, 0 = UART.
- uart_rst_o  out  1  UART loader reset, active high.
- cpu_rst_o  out  1  CPU reset, active high.
- cpu_en_o  out  1  CPU clock enable.
- loaded_o  out  1  a complete UART image has been received since the last UART entry.
- state_o  out  2  current state code, for the MMIO status register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State = WARMUP, all counters 0.
  - Outputs: mode_o=1, uart_rst_o=1, cpu_rst_o=1, cpu_en_o=0, loaded_o=0, state_o=2'd0.
- Synchronisers: 2-flop synchroniser on each of uart_btn_i, work_btn_i and uart_done_i; all logic below uses the synchronised versions.
- Debounce, one counter per button:
  - Synchronised level high: counter increments, saturating at DEBOUNCE_CYCLES. Level low: counter clears to 0.
  - Debounced level = (counter == DEBOUNCE_CYCLES).
  - Press pulse = single-cycle rising edge of the debounced level. Holding the button gives exactly one pulse; a glitch shorter than DEBOUNCE_CYCLES gives none.
- State codes: WARMUP=0, RUN=1, UART_LOAD=2, UART_DONE=3.
- Transitions, evaluated each posedge:
  - WARMUP:
    - warm counter increments each cycle.
    - counter == WARMUP_CYCLES -> RUN, counter cleared.
    - work press -> restart counter at 0.
    - uart press -> UART_LOAD.
  - RUN:
    - uart press -> UART_LOAD.
    - work press ignored.
  - UART_LOAD:
    - rising edge of synchronised uart_done -> UART_DONE.
    - work press -> WARMUP, counter 0.
    - uart press ignored.
    - uart_done already high at entry does not count: only a rising edge does.
  - UART_DONE:
    - work press -> WARMUP, counter 0.
    - uart press -> UART_LOAD.
  - Simultaneous work and uart presses in the same cycle: work wins in every state.
- Outputs are registered from the next-state value, so they change on the same edge as the state.
  - WARMUP: mode=1, uart_rst=1, cpu_rst=0, cpu_en=0.
  - RUN: mode=1, uart_rst=1, cpu_rst=0, cpu_en=1.
  - UART_LOAD / UART_DONE: mode=0, uart_rst=0, cpu_rst=1, cpu_en=0.
- cpu_en_o rises exactly WARMUP_CYCLES+1 cycles after WARMUP entry.
- loaded_o:
  - Set on entry to UART_DONE.
  - Cleared on entry to UART_LOAD.
  - Held through WARMUP and RUN.
- Reset mid-operation (e.g. during UART_LOAD): immediate return to reset values; loaded_o cleared.

Optional Feature:
- Macro: BOOT_MODE_AUTORUN_EN.
- Defined: UART_DONE lasts exactly one cycle, then transitions to WARMUP automatically. Loaded_o stays set, and the CPU boots the new image with no button press. A uart press in that single cycle still wins.
- Undefined: UART_DONE is held until a button press, as above.

Test Plan (DEBOUNCE_CYCLES=4, WARMUP_CYCLES=8):
- Release rst_n, no buttons -> cpu_rst_o=0 from the first edge; cpu_en_o=1 and state_o=1 exactly 9 cycles after reset release.
- In RUN, uart_btn_i high for 10 cycles -> one press pulse; state_o=2, mode_o=0, cpu_rst_o=1, uart_rst_o=0, cpu_en_o=0, loaded_o=0.
- In UART_LOAD, pulse uart_done_i -> state_o=3 and loaded_o=1 three cycles later; then work press -> WARMUP, and cpu_en_o=1 after 9 more cycles with loaded_o still 1.
- Button glitch of 3 cycles high, any state -> no state change; 4+ cycles high -> exactly one transition.
- In RUN, both buttons rise in the same cycle for 6 cycles -> work wins, state stays RUN.
- Assert rst_n low mid-UART_LOAD -> outputs asynchronously return to reset values and loaded_o=0. With BOOT_MODE_AUTORUN_EN defined, uart_done goes from UART_DONE straight to WARMUP after 1 cycle.

Source files
------------

// File: rtl/boot_mode_seq_if.sv
// Control bundle between the board-level pins/loader and the boot mode sequencer.
// master: button pins, loader done flag and the consumers of the sequencer controls.
// slave:  the boot_mode_seq block itself.
interface boot_mode_seq_if;
  logic       uart_btn_i;
  logic       work_btn_i;
  logic       uart_done_i;
  logic       mode_o;
  logic       uart_rst_o;
  logic       cpu_rst_o;
  logic       cpu_en_o;
  logic       loaded_o;
  logic [1:0] state_o;

  modport master (
    output uart_btn_i, work_btn_i, uart_done_i,
    input  mode_o, uart_rst_o, cpu_rst_o, cpu_en_o, loaded_o, state_o
  );

  modport slave (
    input  uart_btn_i, work_btn_i, uart_done_i,
    output mode_o, uart_rst_o, cpu_rst_o, cpu_en_o, loaded_o, state_o
  );
endinterface

// File: rtl/boot_mode_seq.sv
// Boot mode sequencer: debounces the UART/WORK buttons, tracks the UART loader
// done flag and drives registered mode/reset/enable controls for the board.
// Optional build macro BOOT_MODE_AUTORUN_EN: UART_DONE lasts a single cycle and
// then falls into WARMUP so the freshly loaded image boots without a button.
module boot_mode_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned WARMUP_CYCLES   = 255,
  parameter int unsigned CNT_W           = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  boot_mode_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] WARM_MAX = CNT_W'(WARMUP_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_WARMUP    = 2'd0,
    ST_RUN       = 2'd1,
    ST_UART_LOAD = 2'd2,
    ST_UART_DONE = 2'd3
  } state_e;

  logic [1:0]       uart_sync;
  logic [1:0]       work_sync;
  logic [1:0]       done_sync;
  logic             done_q;
  logic [CNT_W-1:0] uart_cnt;
  logic [CNT_W-1:0] work_cnt;
  logic             uart_deb_q;
  logic             work_deb_q;
  logic             uart_deb;
  logic             work_deb;
  logic             uart_press;
  logic             work_press;
  logic             done_rise;

  state_e           state;
  state_e           nxt_state;
  logic [CNT_W-1:0] warm_cnt;
  logic [CNT_W-1:0] nxt_warm;
  logic             loaded_q;
  logic             nxt_loaded;
  logic             mode_q;
  logic             uart_rst_q;
  logic             cpu_rst_q;
  logic             cpu_en_q;

  // Two-flop synchronisers for the asynchronous button pins and loader done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_sync <= 2'b00;
      work_sync <= 2'b00;
      done_sync <= 2'b00;
      done_q    <= 1'b0;
    end else begin
      uart_sync <= {uart_sync[0], bus.uart_btn_i};
      work_sync <= {work_sync[0], bus.work_btn_i};
      done_sync <= {done_sync[0], bus.uart_done_i};
      done_q    <= done_sync[1];
    end
  end

  // Saturating debounce counters; a low sample restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_cnt   <= '0;
      work_cnt   <= '0;
      uart_deb_q <= 1'b0;
      work_deb_q <= 1'b0;
    end else begin
      if (!uart_sync[1])          uart_cnt <= '0;
      else if (uart_cnt != DEB_MAX) uart_cnt <= uart_cnt + CNT_ONE;
      if (!work_sync[1])          work_cnt <= '0;
      else if (work_cnt != DEB_MAX) work_cnt <= work_cnt + CNT_ONE;
      uart_deb_q <= uart_deb;
      work_deb_q <= work_deb;
    end
  end

  assign uart_deb   = (uart_cnt == DEB_MAX);
  assign work_deb   = (work_cnt == DEB_MAX);
  assign uart_press = uart_deb & ~uart_deb_q;
  assign work_press = work_deb & ~work_deb_q;
  assign done_rise  = done_sync[1] & ~done_q;

  // Next-state, warm-up counter and loaded flag; work press always has priority
  always_comb begin
    nxt_state  = state;
    nxt_warm   = '0;
    nxt_loaded = loaded_q;
    case (state)
      ST_WARMUP: begin
        if (work_press) begin
          nxt_warm = '0;
        end else if (uart_press) begin
          nxt_state  = ST_UART_LOAD;
          nxt_loaded = 1'b0;
        end else if (warm_cnt == WARM_MAX) begin
          nxt_state = ST_RUN;
        end else begin
          nxt_warm = warm_cnt + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!work_press && uart_press) begin
          nxt_state  = ST_UART_LOAD;
          nxt_loaded = 1'b0;
        end
      end
      ST_UART_LOAD: begin
        if (work_press) begin
          nxt_state = ST_WARMUP;
        end else if (done_rise) begin
          nxt_state  = ST_UART_DONE;
          nxt_loaded = 1'b1;
        end
      end
      ST_UART_DONE: begin
        if (work_press) begin
          nxt_state = ST_WARMUP;
        end else if (uart_press) begin
          nxt_state  = ST_UART_LOAD;
          nxt_loaded = 1'b0;
        end else begin
`ifdef BOOT_MODE_AUTORUN_EN
          nxt_state = ST_WARMUP;
`else
          nxt_state = ST_UART_DONE;
`endif
        end
      end
      default: nxt_state = ST_WARMUP;
    endcase
  end

  // State register with outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_WARMUP;
      warm_cnt   <= '0;
      loaded_q   <= 1'b0;
      mode_q     <= 1'b1;
      uart_rst_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      cpu_en_q   <= 1'b0;
    end else begin
      state      <= nxt_state;
      warm_cnt   <= nxt_warm;
      loaded_q   <= nxt_loaded;
      mode_q     <= (nxt_state == ST_WARMUP) || (nxt_state == ST_RUN);
      uart_rst_q <= (nxt_state == ST_WARMUP) || (nxt_state == ST_RUN);
      cpu_rst_q  <= (nxt_state == ST_UART_LOAD) || (nxt_state == ST_UART_DONE);
      cpu_en_q   <= (nxt_state == ST_RUN);
    end
  end

  assign bus.mode_o     = mode_q;
  assign bus.uart_rst_o = uart_rst_q;
  assign bus.cpu_rst_o  = cpu_rst_q;
  assign bus.cpu_en_o   = cpu_en_q;
  assign bus.loaded_o   = loaded_q;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_boot_mode_seq.sv
// Scoreboard bench for boot_mode_seq: a reference model predicts the output
// vector for every clock edge, a monitor compares it on the falling edge.
module tb_boot_mode_seq;

  localparam int unsigned D = 4;
  localparam int unsigned W = 8;
  localparam logic [6:0] RST_VEC = 7'b00_111_0_0;

  logic clk;
  logic rst_n;
  boot_mode_seq_if bus ();

  boot_mode_seq #(
    .DEBOUNCE_CYCLES(D),
    .WARMUP_CYCLES  (W),
    .CNT_W          (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [6:0] exp_q[$];

  // Reference model: states 0..3, time measured in stepped clock edges
  int n = 0;
  int entry = 0;
  int st = 0;
  bit loaded = 1'b0;
  int run_u = 0;
  int run_w = 0;
  bit eq_u[1:3];
  bit eq_w[1:3];
  bit rd[1:3];

  function automatic logic [6:0] actual();
    return {bus.state_o, bus.mode_o, bus.uart_rst_o, bus.cpu_rst_o, bus.cpu_en_o, bus.loaded_o};
  endfunction

  function automatic logic [6:0] model_vec(input int s, input bit l);
    case (s)
      0:       return {2'd0, 1'b1, 1'b1, 1'b0, 1'b0, l};
      1:       return {2'd1, 1'b1, 1'b1, 1'b0, 1'b1, l};
      2:       return {2'd2, 1'b0, 1'b0, 1'b1, 1'b0, l};
      default: return {2'd3, 1'b0, 1'b0, 1'b1, 1'b0, l};
    endcase
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got state=%0d mode=%b urst=%b crst=%b en=%b ld=%b want state=%0d mode=%b urst=%b crst=%b en=%b ld=%b",
               name, cyc, act[6:5], act[4], act[3], act[2], act[1], act[0],
               exp[6:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Model step on every rising edge; pushes the expected output vector
  always @(posedge clk) begin
    bit wp, up, dr;
    if (!rst_n) begin
      n = 0; entry = 0; st = 0; loaded = 1'b0; run_u = 0; run_w = 0;
      for (int i = 1; i <= 3; i++) begin eq_u[i] = 1'b0; eq_w[i] = 1'b0; rd[i] = 1'b0; end
      exp_q.push_back(RST_VEC);
    end else begin
      n++;
      // a press is seen 3 edges after the raw run of highs first reaches D
      wp = eq_w[3];
      up = eq_u[3];
      dr = rd[2] && !rd[3];
      for (int i = 3; i > 1; i--) begin eq_u[i] = eq_u[i-1]; eq_w[i] = eq_w[i-1]; rd[i] = rd[i-1]; end
      run_u = bus.uart_btn_i ? run_u + 1 : 0;
      run_w = bus.work_btn_i ? run_w + 1 : 0;
      eq_u[1] = (run_u == int'(D));
      eq_w[1] = (run_w == int'(D));
      rd[1]   = bus.uart_done_i;
      case (st)
        0: begin
          if (wp) entry = n;
          else if (up) begin st = 2; loaded = 1'b0; end
          else if (n - entry == int'(W) + 1) st = 1;
        end
        1: if (!wp && up) begin st = 2; loaded = 1'b0; end
        2: begin
          if (wp) begin st = 0; entry = n; end
          else if (dr) begin st = 3; loaded = 1'b1; end
        end
        default: begin
          if (wp) begin st = 0; entry = n; end
          else if (up) begin st = 2; loaded = 1'b0; end
          else begin
`ifdef BOOT_MODE_AUTORUN_EN
            st = 0; entry = n;
`endif
          end
        end
      endcase
      exp_q.push_back(model_vec(st, loaded));
    end
  end

  // Monitor: compare each predicted vector away from the rising edge
  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) check("outputs", actual(), exp_q.pop_front());
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press(input bit u, input bit w, input int len);
    @(negedge clk);
    bus.uart_btn_i = u;
    bus.work_btn_i = w;
    repeat (len) @(negedge clk);
    bus.uart_btn_i = 1'b0;
    bus.work_btn_i = 1'b0;
  endtask

  task automatic done_pulse(input int len);
    @(negedge clk);
    bus.uart_done_i = 1'b1;
    repeat (len) @(negedge clk);
    bus.uart_done_i = 1'b0;
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("async_reset", actual(), RST_VEC);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.uart_btn_i  = 1'b0;
    bus.work_btn_i  = 1'b0;
    bus.uart_done_i = 1'b0;
    idle(3);
    #1 rst_n = 1'b1;
    idle(12);
    press(1'b1, 1'b0, 10);
    idle(5);
    done_pulse(3);
    idle(6);
    press(1'b0, 1'b1, 6);
    idle(15);
    press(1'b1, 1'b0, 3);
    idle(6);
    press(1'b0, 1'b1, 3);
    idle(6);
    press(1'b1, 1'b1, 6);
    idle(10);
    press(1'b1, 1'b0, 6);
    idle(4);
    bus.uart_done_i = 1'b1;
    idle(2);
    mid_reset();
    bus.uart_done_i = 1'b0;
    idle(12);
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 6))
        0: press(1'b1, 1'b0, int'($urandom_range(1, 7)));
        1: press(1'b0, 1'b1, int'($urandom_range(1, 7)));
        2: press(1'b1, 1'b1, int'($urandom_range(2, 7)));
        3: done_pulse(int'($urandom_range(1, 4)));
        4: idle(int'($urandom_range(1, 14)));
        5: begin
          bus.uart_done_i = ~bus.uart_done_i;
          idle(int'($urandom_range(1, 6)));
        end
        default: begin
          if ($urandom_range(0, 3) == 0) begin
            bus.uart_done_i = 1'b0;
            mid_reset();
          end else begin
            idle(int'($urandom_range(1, 4)));
          end
        end
      endcase
    end
    bus.uart_done_i = 1'b0;
    idle(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
